// File: rtl/sobel_window_gradient.sv
// Streaming 3x3 Sobel gradient magnitudes (|Gx|, |Gy|) over a raster-order 8-bit frame.
// Two row line buffers feed a shifting 3x3 window; results appear two edges after the completing pixel.
module sobel_window_gradient #(
   parameter int unsigned IMG_WIDTH  = 16,
   parameter int unsigned IMG_HEIGHT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  pixel_in,
   input  logic        pixel_valid,
   output logic [10:0] gx,
   output logic [10:0] gy,
   output logic        start_t_grad,
   output logic        frame_done
);

   localparam int unsigned CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int unsigned SW = 12;

   typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   col;
   logic [RW-1:0]   row;
   logic            accept;
   logic            col_last, row_last;
   logic [7:0]      lb_a [IMG_WIDTH];
   logic [7:0]      lb_b [IMG_WIDTH];
   logic [7:0]      win  [3][3];
   logic            v1, v2, last1, last2;
   logic [SW-1:0]   pos_x, neg_x, pos_y, neg_y;
   logic signed [SW-1:0] diff_x, diff_y, dx_q, dy_q;

   assign accept   = pixel_valid & ~rst;
   assign col_last = (col == CW'(IMG_WIDTH - 1));
   assign row_last = (row == RW'(IMG_HEIGHT - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = FILL;
         FILL:    if (accept && row == RW'(1) && col_last) state_nx = STREAM;
         STREAM:  if (accept && row_last && col_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // lb_a holds the row above the current one, lb_b the row above that
   always_ff @(posedge clk) begin
      if (accept) begin
         lb_b[col] <= lb_a[col];
         lb_a[col] <= pixel_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win[r][c] <= '0;
      end else if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= lb_b[col];
         win[1][2] <= lb_a[col];
         win[2][2] <= pixel_in;
      end
   end

   always_comb begin
      pos_x  = SW'(win[0][2]) + SW'({win[1][2], 1'b0}) + SW'(win[2][2]);
      neg_x  = SW'(win[0][0]) + SW'({win[1][0], 1'b0}) + SW'(win[2][0]);
      pos_y  = SW'(win[2][0]) + SW'({win[2][1], 1'b0}) + SW'(win[2][2]);
      neg_y  = SW'(win[0][0]) + SW'({win[0][1], 1'b0}) + SW'(win[0][2]);
      diff_x = $signed(pos_x - neg_x);
      diff_y = $signed(pos_y - neg_y);
   end

   // Stage 1 captures signed gradients of a completed window; stage 2 takes magnitudes
   always_ff @(posedge clk) begin
      if (rst) begin
         v1           <= 1'b0;
         v2           <= 1'b0;
         last1        <= 1'b0;
         last2        <= 1'b0;
         dx_q         <= '0;
         dy_q         <= '0;
         gx           <= '0;
         gy           <= '0;
         start_t_grad <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         v1    <= accept && (row >= RW'(2)) && (col >= CW'(2));
         last1 <= accept && row_last && col_last;
         v2    <= v1;
         last2 <= v1 && last1;
         if (v1) begin
            dx_q <= diff_x;
            dy_q <= diff_y;
         end
         if (v2) begin
            gx <= dx_q[SW-1] ? 11'(-dx_q) : 11'(dx_q);
            gy <= dy_q[SW-1] ? 11'(-dy_q) : 11'(dy_q);
         end
         start_t_grad <= v2;
         frame_done   <= v2 && last2;
      end
   end

endmodule

// File: tb/tb_sobel_window_gradient.sv
// Self-checking bench for sobel_window_gradient: frame-level reference model plus pattern and timing checks.
module tb_sobel_window_gradient;
   localparam int W = 16;
   localparam int H = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  pixel_in = '0;
   logic        pixel_valid = 1'b0;
   logic [10:0] gx, gy;
   logic        start_t_grad, frame_done;

   sobel_window_gradient #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
      .gx(gx), .gy(gy), .start_t_grad(start_t_grad), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int due;
      int gx;
      int gy;
      bit last;
   } exp_t;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t expq[$];
   int   img[H][W];
   int   rnd_img[H][W];
   int   mr = 0, mc = 0;
   int   acc22 = -1;
   int   rst_cnt = 0;
   int   npulse = 0, nfd = 0, last_fd_pulse = 0;
   int   pulse_cyc[$];
   int   lgx[$];
   int   lgy[$];
   exp_t me, ce;

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   function automatic int absi(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Reference model: store the accepted frame and compute each window's gradients directly
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         expq.delete();
         mr = 0;
         mc = 0;
         rst_cnt++;
      end else if (pixel_valid) begin
         img[mr][mc] = int'(pixel_in);
         if (mr >= 2 && mc >= 2) begin
            me.gx = absi((img[mr-2][mc] + 2*img[mr-1][mc] + img[mr][mc])
                       - (img[mr-2][mc-2] + 2*img[mr-1][mc-2] + img[mr][mc-2]));
            me.gy = absi((img[mr][mc-2] + 2*img[mr][mc-1] + img[mr][mc])
                       - (img[mr-2][mc-2] + 2*img[mr-2][mc-1] + img[mr-2][mc]));
            me.due  = cyc + 2;
            me.last = (mr == H-1 && mc == W-1);
            expq.push_back(me);
            if (mr == 2 && mc == 2) acc22 = cyc;
         end
         mc++;
         if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
         end
      end
   end

   // Compare every cycle: pulse exactly when due, values match, otherwise outputs hold
   int held_gx = 0, held_gy = 0, seen_rst = 0;
   always @(negedge clk) begin
      if (cyc > 0) begin
         if (seen_rst != rst_cnt) begin
            seen_rst = rst_cnt;
            held_gx  = 0;
            held_gy  = 0;
         end
         while (expq.size() > 0 && expq[0].due < cyc) begin
            chk("missed_pulse", 0, 1);
            void'(expq.pop_front());
         end
         if (expq.size() > 0 && expq[0].due == cyc) begin
            ce = expq.pop_front();
            chk("start_t_grad", int'(start_t_grad), 1);
            chk("gx", int'(gx), ce.gx);
            chk("gy", int'(gy), ce.gy);
            chk("frame_done", int'(frame_done), int'(ce.last));
            held_gx = ce.gx;
            held_gy = ce.gy;
         end else begin
            chk("idle_start", int'(start_t_grad), 0);
            chk("idle_frame_done", int'(frame_done), 0);
            chk("hold_gx", int'(gx), held_gx);
            chk("hold_gy", int'(gy), held_gy);
         end
         if (start_t_grad) begin
            npulse++;
            pulse_cyc.push_back(cyc);
            lgx.push_back(int'(gx));
            lgy.push_back(int'(gy));
            if (frame_done) begin
               nfd++;
               last_fd_pulse = npulse;
            end
         end
      end
   end

   function automatic int pat(input int kind, input int r, input int c);
      case (kind)
         0:       return 100;
         1:       return (c < 8) ? 0 : 255;
         2:       return (r < 8) ? 0 : 255;
         default: return rnd_img[r][c];
      endcase
   endfunction

   task automatic drive_px(input int v, input int gaps);
      @(negedge clk);
      pixel_valid = 1'b1;
      pixel_in    = 8'(v);
      repeat (gaps) begin
         @(negedge clk);
         pixel_valid = 1'b0;
         pixel_in    = 8'($urandom);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         pixel_valid = 1'b0;
      end
   endtask

   // mode 0: continuous, 1: valid toggled 1/0, 2: random gaps
   task automatic send_frame(input int kind, input int mode);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            drive_px(pat(kind, r, c), (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2)));
   endtask

   initial begin
      int b, b2, f, n1020, nnz;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            rnd_img[r][c] = int'($urandom_range(0, 255));
      repeat (3) @(negedge clk);
      chk("reset_gx", int'(gx), 0);
      chk("reset_start", int'(start_t_grad), 0);
      rst = 1'b0;
      idle(2);

      // constant frame
      b = npulse; f = nfd;
      send_frame(0, 0);
      idle(4);
      chk("const_pulses", npulse - b, 196);
      chk("const_frame_done", nfd - f, 1);
      chk("const_fd_on_last", last_fd_pulse - b, 196);
      chk("first_latency", pulse_cyc[b] - acc22, 2);
      nnz = 0;
      for (int i = b; i < npulse; i++) if (lgx[i] != 0 || lgy[i] != 0) nnz++;
      chk("const_all_zero", nnz, 0);

      // vertical edge
      b = npulse;
      send_frame(1, 0);
      idle(4);
      n1020 = 0; nnz = 0;
      for (int i = b; i < npulse; i++) begin
         if (lgx[i] == 1020) n1020++;
         if (lgx[i] != 0 || lgy[i] != 0) nnz++;
      end
      chk("vedge_gx1020", n1020, 28);
      chk("vedge_nonzero", nnz, 28);

      // horizontal edge
      b = npulse;
      send_frame(2, 0);
      idle(4);
      n1020 = 0; nnz = 0;
      for (int i = b; i < npulse; i++) begin
         if (lgy[i] == 1020) n1020++;
         if (lgx[i] != 0 || lgy[i] != 0) nnz++;
      end
      chk("hedge_gy1020", n1020, 28);
      chk("hedge_nonzero", nnz, 28);

      // random frame: continuous vs toggled vs random gaps
      b = npulse;
      send_frame(3, 0);
      idle(4);
      b2 = npulse;
      send_frame(3, 1);
      idle(4);
      chk("toggle_pulses", npulse - b2, 196);
      for (int i = 0; i < 196; i++) begin
         chk("toggle_seq_gx", lgx[b2+i], lgx[b+i]);
         chk("toggle_seq_gy", lgy[b2+i], lgy[b+i]);
      end
      b2 = npulse;
      send_frame(3, 2);
      idle(4);
      chk("gaps_pulses", npulse - b2, 196);
      for (int i = 0; i < 196; i++) chk("gaps_seq_gx", lgx[b2+i], lgx[b+i]);

      // mid-frame reset after 40 pixels
      b = npulse;
      for (int i = 0; i < 40; i++) drive_px(100, 0);
      @(negedge clk);
      rst = 1'b1;
      pixel_valid = 1'b1;
      pixel_in = 8'd77;
      @(negedge clk);
      rst = 1'b0;
      pixel_valid = 1'b0;
      idle(3);
      chk("pre_rst_pulses", npulse - b, 4);
      chk("post_rst_gx", int'(gx), 0);
      b = npulse; f = nfd;
      send_frame(0, 0);
      idle(4);
      chk("after_rst_pulses", npulse - b, 196);
      chk("after_rst_latency", pulse_cyc[b] - acc22, 2);
      chk("after_rst_frame_done", nfd - f, 1);

      // back-to-back frames
      b = npulse; f = nfd;
      send_frame(3, 0);
      send_frame(0, 0);
      idle(4);
      chk("b2b_pulses", npulse - b, 392);
      chk("b2b_frame_done", nfd - f, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sobel_window_gradient.md
SOBEL_WINDOW_GRADIENT -- requirements
Module: sobel_window_gradient

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 16, pixels per row (at least 3).
REQ-002 SHALL have parameter IMG_HEIGHT, default 16, rows per frame (at least 3).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pixel_in  input  8  grayscale pixel, raster order (row-major, row 0 col 0 first).
REQ-006 SHALL have port pixel_valid  input  1  pixel_in accepted on any edge where high; no backpressure.
REQ-007 SHALL have port gx  output  11  |Gx| of current 3x3 window, unsigned, registered.
REQ-008 SHALL have port gy  output  11  |Gy| of current 3x3 window, unsigned, registered.
REQ-009 SHALL have port start_t_grad  output  1  one-cycle pulse; gx/gy valid for the downstream total_gradient stage.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse marking the final output of a frame.

Function
REQ-011 SHALL keep col and row counters; col increments per accepted pixel and wraps IMG_WIDTH-1 -> 0, incrementing row; row wraps IMG_HEIGHT-1 -> 0.
REQ-012 SHALL keep two line buffers of IMG_WIDTH x 8 bits holding the previous two rows, plus a 3x3 register window shifted one column per accepted pixel.
REQ-013 SHALL, with window pRC (R = row 0..2 top-to-bottom, C = col 0..2 left-to-right), compute Gx = (p02+2p12+p22) - (p00+2p10+p20) and Gy = (p20+2p21+p22) - (p00+2p01+p02), signed with no overflow (range -1020..1020).
REQ-014 SHALL output gx = |Gx| and gy = |Gy|, zero-extended to 11 bits (max 1020); no saturation here.
REQ-015 SHALL produce an output only when the accepted pixel is at row >= 2 and col >= 2 (window fully inside the frame); border centres produce no pulse; (IMG_WIDTH-2)*(IMG_HEIGHT-2) pulses per frame.
REQ-016 SHALL assert start_t_grad exactly 2 rising edges after the accepting edge of the window-completing pixel; latency is fixed and independent of pixel_valid gaps.
REQ-017 SHALL hold gx/gy at their last values between pulses; start_t_grad low otherwise.
REQ-018 SHALL have FSM states IDLE, FILL, STREAM.
REQ-019 SHALL transition IDLE -> FILL on the first accepted pixel; FILL -> STREAM when the pixel at row 1, col IMG_WIDTH-1 is accepted; STREAM -> IDLE when the pixel at row IMG_HEIGHT-1, col IMG_WIDTH-1 is accepted.
REQ-020 SHALL leave all counters, state, window and buffers unchanged on edges with pixel_valid low; in-flight pipeline stages still advance.
REQ-021 SHALL assert frame_done in the same cycle as the final start_t_grad pulse of a frame.
REQ-022 SHALL accept a back-to-back next frame starting on the edge after the last pixel, with no dead cycle.

Reset
REQ-023 SHALL on rst force state IDLE, col = 0, row = 0, gx = 0, gy = 0, start_t_grad = 0, frame_done = 0, and clear the window and pipeline-valid flags.
REQ-024 SHALL give rst priority over pixel_valid; a pixel presented during rst is discarded.
REQ-025 SHALL drop a pending output on mid-frame rst (no pulse after rst); the next accepted pixel is treated as row 0 col 0.
REQ-026 SHALL NOT require line-buffer contents to be cleared on reset; no output may depend on stale contents.

Verification
REQ-027 SHALL verify: 16x16 frame of constant 100, continuous valid -> 196 pulses, all gx = 0, gy = 0, frame_done once with pulse 196.
REQ-028 SHALL verify: cols 0-7 = 0, cols 8-15 = 255 -> gx = 1020, gy = 0 at centre cols 7 and 8; gx = 0 elsewhere.
REQ-029 SHALL verify: rows 0-7 = 0, rows 8-15 = 255 -> gy = 1020, gx = 0 at centre rows 7 and 8; gy = 0 elsewhere.
REQ-030 SHALL verify: first pulse exactly 2 edges after pixel index 34 (row 2, col 2) is accepted; pixel_valid toggled 1/0 over a frame -> identical gx/gy sequence to the continuous run.
REQ-031 SHALL verify: rst asserted after 40 pixels, then a full constant-100 frame -> no pulse within 2 cycles after rst, then exactly 196 pulses, first after the 35th post-reset pixel.
REQ-032 SHALL verify: two back-to-back frames -> two frame_done pulses, 392 total start_t_grad pulses, no gap cycle required.
